// File: rtl/bfs_ctrl_regs_if.sv
// Generic register-bus bundle between the AXI4-Lite slave shim and the
// BFS control/status register bank.
interface bfs_ctrl_regs_if #(
   parameter int ADDR_WIDTH = 12,
   parameter int DATA_WIDTH = 32
) ();
   logic [ADDR_WIDTH-1:0] addr;
   logic                  write_en;
   logic [DATA_WIDTH-1:0] write_data;
   logic [DATA_WIDTH-1:0] read_data;

   // Bus side that issues accesses (AXI shim or testbench).
   modport master (
      output addr,
      output write_en,
      output write_data,
      input  read_data
   );

   // Register bank side.
   modport slave (
      input  addr,
      input  write_en,
      input  write_data,
      output read_data
   );
endinterface

// File: rtl/bfs_ctrl_regs.sv
// BFS accelerator control/status register bank and run sequencer.
// Holds the graph configuration, launches the core with a one-cycle pulse,
// supervises it (abort / timeout) and reports completion via sticky status
// bits and a level interrupt.
module bfs_ctrl_regs #(
   parameter int          ADDR_WIDTH = 12,
   parameter int          DATA_WIDTH = 32,
   parameter logic [31:0] VERSION    = 32'h0001_0000
) (
   input  logic              s_axi_clk,
   input  logic              s_axi_rst_n,
   bfs_ctrl_regs_if.slave    bus,
   output logic              core_start,
   output logic              core_abort,
   output logic [31:0]       core_graph_base,
   output logic [31:0]       core_result_base,
   output logic [31:0]       core_num_vertices,
   output logic [31:0]       core_root_vertex,
   input  logic              core_done,
   input  logic [31:0]       core_visited,
   output logic              irq
);

   // Word indices of the register map (byte offset >> 2).
   localparam int AW = ADDR_WIDTH - 2;
   localparam logic [AW-1:0] W_CTRL    = AW'(0);
   localparam logic [AW-1:0] W_STATUS  = AW'(1);
   localparam logic [AW-1:0] W_GRAPH   = AW'(2);
   localparam logic [AW-1:0] W_RESULT  = AW'(3);
   localparam logic [AW-1:0] W_NUMV    = AW'(4);
   localparam logic [AW-1:0] W_ROOT    = AW'(5);
   localparam logic [AW-1:0] W_TLIMIT  = AW'(6);
   localparam logic [AW-1:0] W_CYCLES  = AW'(7);
   localparam logic [AW-1:0] W_VISITED = AW'(8);
   localparam logic [AW-1:0] W_VERSION = AW'(9);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_LAUNCH   = 2'd1,
      S_RUN      = 2'd2,
      S_ABORTING = 2'd3
   } state_t;

   state_t r_state;
   state_t w_state_next;

   logic        r_irq_en;
   logic        r_done;
   logic        r_timeout;
   logic        r_aborted;
   logic        r_cfg_err;
   logic [31:0] r_graph_base;
   logic [31:0] r_result_base;
   logic [31:0] r_num_vertices;
   logic [31:0] r_root_vertex;
   logic [31:0] r_timeout_limit;
   logic [31:0] r_cycle_count;
   logic [31:0] r_visited;

   logic [AW-1:0] w_word;
   logic          w_busy;
   logic          w_wr_ctrl;
   logic          w_wr_status;
   logic          w_cfg_wr;
   logic          w_start_req;
   logic          w_cfg_ok;
   logic          w_launch;
   logic          w_cfg_bad;
   logic          w_run_done;
   logic          w_run_abort;
   logic          w_timeout_hit;
   logic          w_w1c_done;
   logic          w_w1c_timeout;
   logic          w_w1c_aborted;
   logic          w_w1c_cfg_err;

   assign w_word      = bus.addr[ADDR_WIDTH-1:2];
   assign w_busy      = (r_state != S_IDLE);
   assign w_wr_ctrl   = bus.write_en && (w_word == W_CTRL);
   assign w_wr_status = bus.write_en && (w_word == W_STATUS);
   // Configuration registers are frozen while the core is running.
   assign w_cfg_wr    = bus.write_en && !w_busy;

   assign w_start_req = w_wr_ctrl && bus.write_data[0] && (r_state == S_IDLE);
   assign w_cfg_ok    = (r_num_vertices != 32'd0) && (r_root_vertex < r_num_vertices);
   assign w_launch    = w_start_req && w_cfg_ok;
   assign w_cfg_bad   = w_start_req && !w_cfg_ok;

   // Completion takes priority over both abort request and timeout.
   assign w_run_done    = (r_state == S_RUN) && core_done;
   assign w_run_abort   = (r_state == S_RUN) && !core_done && w_wr_ctrl && bus.write_data[1];
   assign w_timeout_hit = (r_state == S_RUN) && !core_done && (r_timeout_limit != 32'd0)
                          && (r_cycle_count == r_timeout_limit - 32'd1);

   assign w_w1c_done    = w_wr_status && bus.write_data[1];
   assign w_w1c_timeout = w_wr_status && bus.write_data[2];
   assign w_w1c_aborted = w_wr_status && bus.write_data[3];
   assign w_w1c_cfg_err = w_wr_status && bus.write_data[4];

   // State register.
   always_ff @(posedge s_axi_clk or negedge s_axi_rst_n) begin
      if (!s_axi_rst_n) r_state <= S_IDLE;
      else              r_state <= w_state_next;
   end

   // Next-state logic.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:     if (w_launch) w_state_next = S_LAUNCH;
         S_LAUNCH:   w_state_next = S_RUN;
         S_RUN: begin
            if (core_done)                        w_state_next = S_IDLE;
            else if (w_run_abort || w_timeout_hit) w_state_next = S_ABORTING;
         end
         S_ABORTING: if (core_done) w_state_next = S_IDLE;
         default:    w_state_next = S_IDLE;
      endcase
   end

   // FSM outputs; purely state-decoded so reset drops them asynchronously.
   always_comb begin
      core_start = (r_state == S_LAUNCH);
      core_abort = (r_state == S_ABORTING);
   end

   // Sticky status bits: hardware set beats a same-cycle W1C; launch clears run results.
   always_ff @(posedge s_axi_clk or negedge s_axi_rst_n) begin
      if (!s_axi_rst_n) begin
         r_done    <= 1'b0;
         r_timeout <= 1'b0;
         r_aborted <= 1'b0;
         r_cfg_err <= 1'b0;
      end else begin
         if (w_launch) begin
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
            r_aborted <= 1'b0;
         end else begin
            r_done    <= w_run_done    | (r_done    & ~w_w1c_done);
            r_timeout <= w_timeout_hit | (r_timeout & ~w_w1c_timeout);
            r_aborted <= w_run_abort   | (r_aborted & ~w_w1c_aborted);
         end
         r_cfg_err <= w_cfg_bad | (r_cfg_err & ~w_w1c_cfg_err);
      end
   end

   // Control and configuration registers written from the bus.
   always_ff @(posedge s_axi_clk or negedge s_axi_rst_n) begin
      if (!s_axi_rst_n) begin
         r_irq_en        <= 1'b0;
         r_graph_base    <= 32'd0;
         r_result_base   <= 32'd0;
         r_num_vertices  <= 32'd0;
         r_root_vertex   <= 32'd0;
         r_timeout_limit <= 32'd0;
      end else begin
         if (w_wr_ctrl) r_irq_en <= bus.write_data[2];
         if (w_cfg_wr) begin
            case (w_word)
               W_GRAPH:  r_graph_base    <= bus.write_data[31:0];
               W_RESULT: r_result_base   <= bus.write_data[31:0];
               W_NUMV:   r_num_vertices  <= bus.write_data[31:0];
               W_ROOT:   r_root_vertex   <= bus.write_data[31:0];
               W_TLIMIT: r_timeout_limit <= bus.write_data[31:0];
               default:  ;
            endcase
         end
      end
   end

   // Run-cycle counter (saturating) and visited-count capture on completion.
   always_ff @(posedge s_axi_clk or negedge s_axi_rst_n) begin
      if (!s_axi_rst_n) begin
         r_cycle_count <= 32'd0;
         r_visited     <= 32'd0;
      end else begin
         if (w_launch)
            r_cycle_count <= 32'd0;
         else if ((r_state == S_RUN) && (r_cycle_count != 32'hFFFF_FFFF))
            r_cycle_count <= r_cycle_count + 32'd1;
         if (w_run_done) r_visited <= core_visited;
      end
   end

   // Combinational register read mux; START/ABORT always read back as 0.
   always_comb begin
      bus.read_data = '0;
      case (w_word)
         W_CTRL:    bus.read_data[2:0] = {r_irq_en, 2'b00};
         W_STATUS:  bus.read_data[4:0] = {r_cfg_err, r_aborted, r_timeout, r_done, w_busy};
         W_GRAPH:   bus.read_data[31:0] = r_graph_base;
         W_RESULT:  bus.read_data[31:0] = r_result_base;
         W_NUMV:    bus.read_data[31:0] = r_num_vertices;
         W_ROOT:    bus.read_data[31:0] = r_root_vertex;
         W_TLIMIT:  bus.read_data[31:0] = r_timeout_limit;
         W_CYCLES:  bus.read_data[31:0] = r_cycle_count;
         W_VISITED: bus.read_data[31:0] = r_visited;
         W_VERSION: bus.read_data[31:0] = VERSION;
         default:   bus.read_data = '0;
      endcase
   end

   assign core_graph_base   = r_graph_base;
   assign core_result_base  = r_result_base;
   assign core_num_vertices = r_num_vertices;
   assign core_root_vertex  = r_root_vertex;
   assign irq = r_irq_en & (r_done | r_timeout | r_aborted | r_cfg_err);

endmodule

// File: tb/tb_bfs_ctrl_regs.sv
// Directed testbench for bfs_ctrl_regs: register map, launch/complete,
// configuration error, timeout, abort, busy write protection, races, reset.
module tb_bfs_ctrl_regs;

   logic        s_axi_clk;
   logic        s_axi_rst_n;
   logic        core_start;
   logic        core_abort;
   logic [31:0] core_graph_base;
   logic [31:0] core_result_base;
   logic [31:0] core_num_vertices;
   logic [31:0] core_root_vertex;
   logic        core_done;
   logic [31:0] core_visited;
   logic        irq;

   int checks;
   int failures;
   int start_cnt;

   bfs_ctrl_regs_if #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) bus_if ();

   bfs_ctrl_regs #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .VERSION(32'h0001_0000)) dut (
      .s_axi_clk        (s_axi_clk),
      .s_axi_rst_n      (s_axi_rst_n),
      .bus              (bus_if),
      .core_start       (core_start),
      .core_abort       (core_abort),
      .core_graph_base  (core_graph_base),
      .core_result_base (core_result_base),
      .core_num_vertices(core_num_vertices),
      .core_root_vertex (core_root_vertex),
      .core_done        (core_done),
      .core_visited     (core_visited),
      .irq              (irq)
   );

   initial s_axi_clk = 1'b0;
   always #5 s_axi_clk = ~s_axi_clk;

   // Count launch pulses, sampled mid-cycle.
   always @(negedge s_axi_clk) if (core_start === 1'b1) start_cnt++;

   // One-cycle write; call at a negedge, returns at the next negedge.
   task automatic wr(input logic [11:0] a, input logic [31:0] d);
      bus_if.addr       = a;
      bus_if.write_data = d;
      bus_if.write_en   = 1'b1;
      @(negedge s_axi_clk);
      bus_if.write_en   = 1'b0;
      $display("write addr=0x%03h data=0x%08h", a, d);
   endtask

   // Combinational read, no clock consumed.
   task automatic rd(input logic [11:0] a, output logic [31:0] d);
      bus_if.addr = a;
      #1;
      d = bus_if.read_data;
      $display("read  addr=0x%03h data=0x%08h", a, d);
   endtask

   task automatic test_reset();
      logic [31:0] v;
      logic [31:0] exp;
      for (int i = 0; i <= 11; i++) begin
         rd(12'(i * 4), v);
         exp = (i == 9) ? 32'h0001_0000 : 32'h0;
         checks++;
         if (v !== exp) begin
            failures++;
            $display("FAIL reset_read off=0x%02h got=0x%08h exp=0x%08h", i * 4, v, exp);
         end
      end
      checks++;
      if ({core_start, core_abort, irq} !== 3'b000) begin
         failures++;
         $display("FAIL reset_outputs got=%b exp=000", {core_start, core_abort, irq});
      end
      checks++;
      if ({core_graph_base, core_result_base, core_num_vertices, core_root_vertex} !== 128'd0) begin
         failures++;
         $display("FAIL reset_cfg_outputs nonzero");
      end
   endtask

   task automatic test_run();
      logic [31:0] v;
      int s0;
      wr(12'h10, 32'd16);
      wr(12'h14, 32'd3);
      checks++;
      if (core_num_vertices !== 32'd16) begin
         failures++;
         $display("FAIL cfg_visible got=%0d exp=16", core_num_vertices);
      end
      s0 = start_cnt;
      wr(12'h00, 32'h5);               // IRQ_EN + START, now in LAUNCH
      checks++;
      if (core_start !== 1'b1) begin
         failures++;
         $display("FAIL launch_pulse got=%b exp=1", core_start);
      end
      rd(12'h00, v);
      checks++;
      if (v !== 32'h4) begin
         failures++;
         $display("FAIL ctrl_readback got=0x%08h exp=0x00000004", v);
      end
      rd(12'h04, v);
      checks++;
      if (v !== 32'h1) begin
         failures++;
         $display("FAIL busy_in_launch got=0x%08h exp=0x00000001", v);
      end
      @(negedge s_axi_clk);            // RUN cycle 1
      repeat (9) @(negedge s_axi_clk); // RUN cycle 10
      core_done = 1'b1; core_visited = 32'd16;
      @(negedge s_axi_clk);
      core_done = 1'b0;
      rd(12'h04, v);
      checks++;
      if (v !== 32'h2) begin
         failures++;
         $display("FAIL run_status got=0x%08h exp=0x00000002", v);
      end
      rd(12'h1C, v);
      checks++;
      if (v !== 32'd10) begin
         failures++;
         $display("FAIL run_cycles got=%0d exp=10", v);
      end
      rd(12'h20, v);
      checks++;
      if (v !== 32'd16) begin
         failures++;
         $display("FAIL run_visited got=%0d exp=16", v);
      end
      checks++;
      if (irq !== 1'b1) begin
         failures++;
         $display("FAIL run_irq got=%b exp=1", irq);
      end
      checks++;
      if (start_cnt - s0 !== 1) begin
         failures++;
         $display("FAIL start_pulses got=%0d exp=1", start_cnt - s0);
      end
      @(negedge s_axi_clk);
      wr(12'h04, 32'h2);
      checks++;
      if (irq !== 1'b0) begin
         failures++;
         $display("FAIL w1c_irq got=%b exp=0", irq);
      end
   endtask

   task automatic test_cfg_err();
      logic [31:0] v;
      int s0;
      @(negedge s_axi_clk);
      wr(12'h14, 32'd16);
      s0 = start_cnt;
      wr(12'h00, 32'h5);
      repeat (2) @(negedge s_axi_clk);
      rd(12'h04, v);
      checks++;
      if (v !== 32'h10) begin
         failures++;
         $display("FAIL cfg_err_status got=0x%08h exp=0x00000010", v);
      end
      checks++;
      if (start_cnt !== s0) begin
         failures++;
         $display("FAIL cfg_err_pulse got=%0d exp=0", start_cnt - s0);
      end
      @(negedge s_axi_clk);
      wr(12'h04, 32'h10);
      wr(12'h14, 32'd3);
   endtask

   task automatic test_timeout();
      logic [31:0] v;
      wr(12'h18, 32'd5);
      wr(12'h00, 32'h5);               // LAUNCH
      @(negedge s_axi_clk);            // RUN 1
      repeat (4) @(negedge s_axi_clk); // RUN 5
      checks++;
      if (core_abort !== 1'b0) begin
         failures++;
         $display("FAIL timeout_early got=%b exp=0", core_abort);
      end
      @(negedge s_axi_clk);            // ABORTING
      checks++;
      if (core_abort !== 1'b1) begin
         failures++;
         $display("FAIL timeout_abort got=%b exp=1", core_abort);
      end
      repeat (2) @(negedge s_axi_clk);
      core_done = 1'b1; core_visited = 32'd99;
      @(negedge s_axi_clk);
      core_done = 1'b0;
      checks++;
      if (core_abort !== 1'b0) begin
         failures++;
         $display("FAIL timeout_abort_drop got=%b exp=0", core_abort);
      end
      rd(12'h04, v);
      checks++;
      if (v !== 32'h4) begin
         failures++;
         $display("FAIL timeout_status got=0x%08h exp=0x00000004", v);
      end
      rd(12'h20, v);
      checks++;
      if (v !== 32'd16) begin
         failures++;
         $display("FAIL timeout_visited got=%0d exp=16", v);
      end
      rd(12'h1C, v);
      checks++;
      if (v !== 32'd5) begin
         failures++;
         $display("FAIL timeout_cycles got=%0d exp=5", v);
      end
      @(negedge s_axi_clk);
      wr(12'h04, 32'h1F);
      wr(12'h18, 32'd0);
   endtask

   task automatic test_abort();
      logic [31:0] v;
      wr(12'h00, 32'h5);               // LAUNCH
      @(negedge s_axi_clk);            // RUN 1
      wr(12'h00, 32'h6);               // ABORT -> ABORTING
      rd(12'h04, v);
      checks++;
      if (v !== 32'h9 || core_abort !== 1'b1) begin
         failures++;
         $display("FAIL abort_enter status=0x%08h abort=%b exp=0x00000009/1", v, core_abort);
      end
      @(negedge s_axi_clk);
      @(negedge s_axi_clk);
      checks++;
      if (core_abort !== 1'b1) begin
         failures++;
         $display("FAIL abort_hold got=%b exp=1", core_abort);
      end
      core_done = 1'b1; core_visited = 32'd55;
      @(negedge s_axi_clk);
      core_done = 1'b0;
      rd(12'h04, v);
      checks++;
      if (v !== 32'h8 || core_abort !== 1'b0) begin
         failures++;
         $display("FAIL abort_exit status=0x%08h abort=%b exp=0x00000008/0", v, core_abort);
      end
      @(negedge s_axi_clk);
      wr(12'h04, 32'h1F);
   endtask

   task automatic test_busy_write_and_race();
      logic [31:0] v;
      wr(12'h08, 32'h0000_AAAA);
      wr(12'h00, 32'h5);               // LAUNCH
      @(negedge s_axi_clk);            // RUN 1
      wr(12'h08, 32'h0000_1234);       // ignored while BUSY
      checks++;
      if (core_graph_base !== 32'h0000_AAAA) begin
         failures++;
         $display("FAIL busy_write got=0x%08h exp=0x0000aaaa", core_graph_base);
      end
      bus_if.addr = 12'h00; bus_if.write_data = 32'h6; bus_if.write_en = 1'b1;
      core_done = 1'b1; core_visited = 32'd7;
      @(negedge s_axi_clk);
      bus_if.write_en = 1'b0; core_done = 1'b0;
      rd(12'h04, v);
      checks++;
      if (v !== 32'h2 || core_abort !== 1'b0) begin
         failures++;
         $display("FAIL abort_done_race status=0x%08h abort=%b exp=0x00000002/0", v, core_abort);
      end
      rd(12'h20, v);
      checks++;
      if (v !== 32'd7) begin
         failures++;
         $display("FAIL race_visited got=%0d exp=7", v);
      end
   endtask

   task automatic test_w1c_race();
      logic [31:0] v;
      @(negedge s_axi_clk);
      wr(12'h00, 32'h5);               // LAUNCH (clears DONE)
      @(negedge s_axi_clk);            // RUN 1
      bus_if.addr = 12'h04; bus_if.write_data = 32'h2; bus_if.write_en = 1'b1;
      core_done = 1'b1; core_visited = 32'd9;
      @(negedge s_axi_clk);
      bus_if.write_en = 1'b0; core_done = 1'b0;
      rd(12'h04, v);
      checks++;
      if (v !== 32'h2) begin
         failures++;
         $display("FAIL w1c_race got=0x%08h exp=0x00000002", v);
      end
      @(negedge s_axi_clk);
      wr(12'h04, 32'h1F);
   endtask

   task automatic test_reset_midrun();
      logic [31:0] v;
      wr(12'h00, 32'h5);               // LAUNCH
      @(negedge s_axi_clk);            // RUN 1
      wr(12'h00, 32'h6);               // ABORTING, ABORTED set, irq high
      #2;
      s_axi_rst_n = 1'b0;
      #1;
      checks++;
      if ({core_start, core_abort, irq} !== 3'b000) begin
         failures++;
         $display("FAIL async_reset_outputs got=%b exp=000", {core_start, core_abort, irq});
      end
      checks++;
      if (core_graph_base !== 32'd0) begin
         failures++;
         $display("FAIL async_reset_cfg got=0x%08h exp=0x00000000", core_graph_base);
      end
      @(negedge s_axi_clk);
      s_axi_rst_n = 1'b1;
      rd(12'h04, v);
      checks++;
      if (v !== 32'h0) begin
         failures++;
         $display("FAIL reset_status got=0x%08h exp=0x00000000", v);
      end
   endtask

   initial begin
      checks = 0; failures = 0; start_cnt = 0;
      s_axi_rst_n = 1'b0;
      bus_if.addr = '0; bus_if.write_en = 1'b0; bus_if.write_data = '0;
      core_done = 1'b0; core_visited = '0;
      repeat (3) @(negedge s_axi_clk);
      s_axi_rst_n = 1'b1;
      @(negedge s_axi_clk);
      test_reset();
      @(negedge s_axi_clk);
      test_run();
      test_cfg_err();
      test_timeout();
      test_abort();
      test_busy_write_and_race();
      test_w1c_race();
      test_reset_midrun();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
